// File: rtl/pixel_frame_scheduler.sv
// pixel_frame_scheduler
//   Shares the pixel FIFO write port between the host bus writer and the internal
//   test-pattern generator. Arbitration is per frame: once a source is granted, a whole
//   frame of FRAME_WORDS words is written before anyone else is considered. Pattern frames
//   are paced by a free-running period counter. A host frame that stalls mid-way is padded
//   with zero words, so the FIFO always holds whole frames.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   mode              0 host only, 1 pattern only, 2 auto (host first, pattern on host idle), 3 off
//   host_data/valid   host word stream; host_ready is high while the host frame is open
//   pat_data/valid    pattern word stream; pat_ready is high while the pattern frame is open
//   pat_frame_start   1-cycle pulse telling the pattern generator to restart at pixel 0
//   fifo_full_count   current pixel FIFO occupancy
//   fifo_wr_data/en   registered FIFO write port (one cycle after the accepted beat)
//   grant             0 none, 1 host (including padding), 2 pattern
//   frame_done        pulses together with the last write of a frame
//   pad_event         pulses when a stalled host frame switches to zero padding
//   frame_count       completed frames, wrapping
module pixel_frame_scheduler #(
  parameter int N_STRINGS          = 4,
  parameter int N_LEDS_PER_STRING  = 150,
  parameter int FIFO_ADDR_WIDTH    = 12,
  parameter int FIFO_DATA_WIDTH    = 16,
  parameter int FRAME_PERIOD_TICKS = 333333,
  parameter int HOST_TIMEOUT_TICKS = 200000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 mode,
  input  logic [FIFO_DATA_WIDTH-1:0] host_data,
  input  logic                       host_valid,
  output logic                       host_ready,
  input  logic [FIFO_DATA_WIDTH-1:0] pat_data,
  input  logic                       pat_valid,
  output logic                       pat_ready,
  output logic                       pat_frame_start,
  input  logic [FIFO_ADDR_WIDTH:0]   fifo_full_count,
  output logic [FIFO_DATA_WIDTH-1:0] fifo_wr_data,
  output logic                       fifo_wr_en,
  output logic [1:0]                 grant,
  output logic                       frame_done,
  output logic                       pad_event,
  output logic [15:0]                frame_count
);

  localparam int FRAME_WORDS = N_STRINGS * N_LEDS_PER_STRING * 3 / (FIFO_DATA_WIDTH / 8);
  localparam int WCW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int PCW = (FRAME_PERIOD_TICKS > 1) ? $clog2(FRAME_PERIOD_TICKS) : 1;
  localparam int ICW = $clog2(HOST_TIMEOUT_TICKS + 1);

  localparam logic [WCW-1:0]           WORD_LAST   = WCW'(FRAME_WORDS - 1);
  localparam logic [PCW-1:0]           PERIOD_LAST = PCW'(FRAME_PERIOD_TICKS - 1);
  localparam logic [ICW-1:0]           IDLE_LIMIT  = ICW'(HOST_TIMEOUT_TICKS);
  localparam logic [FIFO_ADDR_WIDTH:0] FIFO_DEPTH  = {1'b1, {FIFO_ADDR_WIDTH{1'b0}}};
  localparam logic [FIFO_ADDR_WIDTH:0] FRAME_NEED  = (FIFO_ADDR_WIDTH + 1)'(FRAME_WORDS);

  typedef enum logic [1:0] {IDLE, HOST, PAT, PAD} state_t;

  state_t                     state;
  logic [WCW-1:0]             word_cnt;
  logic [PCW-1:0]             period_cnt;
  logic                       tick_pending;
  logic [ICW-1:0]             host_idle;

  logic [FIFO_ADDR_WIDTH:0]   free;
  logic                       space_ok;
  logic                       period_tick;
  logic                       host_timed_out;
  logic                       host_start;
  logic                       pat_start;
  logic                       beat;
  logic [FIFO_DATA_WIDTH-1:0] beat_data;

  assign host_ready = (state == HOST);
  assign pat_ready  = (state == PAT);

  always_comb begin
    free           = FIFO_DEPTH - fifo_full_count;
    space_ok       = (free >= FRAME_NEED);
    // A tick that could not be used earlier stays available until a pattern frame starts.
    period_tick    = (period_cnt == PERIOD_LAST) || tick_pending;
    host_timed_out = (host_idle >= IDLE_LIMIT);
    host_start     = (state == IDLE) && space_ok && host_valid &&
                     ((mode == 2'd0) || (mode == 2'd2));
    pat_start      = (state == IDLE) && space_ok && !host_start && period_tick &&
                     ((mode == 2'd1) || ((mode == 2'd2) && host_timed_out));
  end

  // One FIFO word is produced per cycle in which the open frame has data to give;
  // padding always has data.
  always_comb begin
    beat      = 1'b0;
    beat_data = '0;
    case (state)
      HOST: begin
        beat      = host_valid;
        beat_data = host_data;
      end
      PAT: begin
        beat      = pat_valid;
        beat_data = pat_data;
      end
      PAD: begin
        beat      = 1'b1;
        beat_data = '0;
      end
      default: ;
    endcase
  end

  // Frame pacing and host inactivity tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      period_cnt   <= '0;
      tick_pending <= 1'b0;
      host_idle    <= '0;
    end else begin
      period_cnt   <= (period_cnt == PERIOD_LAST) ? '0 : period_cnt + PCW'(1);
      tick_pending <= period_tick && !pat_start;
      if (host_valid)
        host_idle <= '0;
      else if (!host_timed_out)
        host_idle <= host_idle + ICW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      word_cnt        <= '0;
      grant           <= 2'd0;
      fifo_wr_data    <= '0;
      fifo_wr_en      <= 1'b0;
      frame_done      <= 1'b0;
      pad_event       <= 1'b0;
      pat_frame_start <= 1'b0;
      frame_count     <= 16'd0;
    end else begin
      fifo_wr_en      <= 1'b0;
      frame_done      <= 1'b0;
      pad_event       <= 1'b0;
      pat_frame_start <= 1'b0;
      if (beat) begin
        fifo_wr_en   <= 1'b1;
        fifo_wr_data <= beat_data;
        if (word_cnt == '0) begin
          state       <= IDLE;
          grant       <= 2'd0;
          frame_done  <= 1'b1;
          frame_count <= frame_count + 16'd1;
        end else begin
          word_cnt <= word_cnt - WCW'(1);
        end
      end else if (state == IDLE) begin
        if (host_start) begin
          state    <= HOST;
          grant    <= 2'd1;
          word_cnt <= WORD_LAST;
        end else if (pat_start) begin
          state           <= PAT;
          grant           <= 2'd2;
          word_cnt        <= WORD_LAST;
          pat_frame_start <= 1'b1;
        end
      end else if ((state == HOST) && host_timed_out) begin
        // Host went quiet mid-frame: finish the frame with zero words.
        state     <= PAD;
        pad_event <= 1'b1;
      end
    end
  end

endmodule
